mem_bus_arbiter: RTL and testbench

Sequences the single shared memory data bus between the instruction-fetch path and the ALU memory-access path (load/store and stack traffic). It grants the bus to one requester at a time and drives the memory-side command (MemIO), address and write-data enable. It completes each access on the memory's ValidMemData strobe and returns read data plus a one-cycle done pulse to the owner. Sits between the fetch unit / ALU and the top-level DataIO tristate.

---
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one memory data bus between the fetch path and the ALU path, one access at a time.
// Optional access watchdog is enabled with the MEM_ARB_TIMEOUT_EN define.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic [DATA_W-1:0] FetchData,
    output logic              FetchDone,
    input  logic              AluReq,
    input  logic              AluWrite,
    input  logic [ADDR_W-1:0] AluAddr,
    input  logic [DATA_W-1:0] AluWData,
    output logic [DATA_W-1:0] AluRData,
    output logic              AluDone,
    output logic [1:0]        MemIO,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWDataOE,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              ValidMemData,
    output logic              Busy,
    output logic              Owner,
    output logic              Timeout
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic [DATA_W-1:0] adata_q, adata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              grant_alu;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fdata_d   = fdata_q;
        adata_d   = adata_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        grant_alu = 1'b0;
        case (state_q)
            S_IDLE: begin
                // On a tie the requester that did not own the bus last goes next.
                grant_alu = AluReq && (!FetchReq || !owner_q);
                if (FetchReq || AluReq) begin
                    state_d = S_ACCESS;
                    owner_d = grant_alu;
                    addr_d  = grant_alu ? AluAddr : FetchAddr;
                    wr_d    = grant_alu && AluWrite;
                    if (grant_alu) wdata_d = AluWData;
                    cnt_d   = 8'd0;
                end
            end
            S_ACCESS: begin
                if (ValidMemData) begin
                    state_d = S_DONE;
                    if (!wr_q) begin
                        if (owner_q) adata_d = MemRData;
                        else         fdata_d = MemRData;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    if (!wr_q) begin
                        if (owner_q) adata_d = '1;
                        else         fdata_d = '1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fdata_q   <= '0;
            adata_q   <= '0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            fdata_q   <= fdata_d;
            adata_q   <= adata_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Bus-side outputs decode from state and latched flags only, never from the requests.
    assign MemIO      = (state_q == S_ACCESS) ? (wr_q ? 2'b10 : 2'b01) : 2'b00;
    assign MemWDataOE = (state_q == S_ACCESS) && wr_q;
    assign MemAddr    = addr_q;
    assign MemWData   = wdata_q;
    assign FetchDone  = (state_q == S_DONE) && !owner_q;
    assign AluDone    = (state_q == S_DONE) && owner_q;
    assign FetchData  = fdata_q;
    assign AluRData   = adata_q;
    assign Busy       = (state_q != S_IDLE);
    assign Owner      = owner_q;

`ifdef MEM_ARB_TIMEOUT_EN
    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
    logic unused_timeout;
    assign unused_timeout = ^{TO_LAST, cnt_q, timeout_q};
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed accesses against a simple memory responder.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        FetchReq = 1'b0, AluReq = 1'b0, AluWrite = 1'b0;
    logic [31:0] FetchAddr = '0, AluAddr = '0, AluWData = '0;
    logic [31:0] FetchData, AluRData, MemAddr, MemWData;
    logic [31:0] MemRData = '0;
    logic        ValidMemData = 1'b0;
    logic        FetchDone, AluDone, MemWDataOE, Busy, Owner, Timeout;
    logic [1:0]  MemIO;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchData(FetchData), .FetchDone(FetchDone),
        .AluReq(AluReq), .AluWrite(AluWrite), .AluAddr(AluAddr), .AluWData(AluWData),
        .AluRData(AluRData), .AluDone(AluDone),
        .MemIO(MemIO), .MemAddr(MemAddr), .MemWData(MemWData), .MemWDataOE(MemWDataOE),
        .MemRData(MemRData), .ValidMemData(ValidMemData),
        .Busy(Busy), .Owner(Owner), .Timeout(Timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic alu; logic [31:0] data; } exp_t;
    exp_t        sb[$];
    exp_t        e;
    int          done_cyc[$];
    int          cyc = 0;
    int          vectors = 0, errors = 0;

    // memory responder state
    int          wait_cfg = 0, acc_cyc = 0, last_len = 0;
    logic [31:0] rdata_cfg = '0, last_addr = '0, last_wdata = '0;
    logic [1:0]  last_io = '0;
    logic        oe_bad = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: returns rdata_cfg ^ address after wait_cfg idle ACCESS cycles.
    always @(negedge clk) begin
        if (rst || MemIO == 2'b00) begin
            acc_cyc      = 0;
            ValidMemData = 1'b0;
        end else begin
            last_len   = acc_cyc + 1;
            last_io    = MemIO;
            last_addr  = MemAddr;
            last_wdata = MemWData;
            if (MemWDataOE !== (MemIO == 2'b10)) oe_bad = 1'b1;
            ValidMemData = (acc_cyc == wait_cfg);
            MemRData     = rdata_cfg ^ MemAddr;
            acc_cyc++;
        end
    end

    // Scoreboard monitor: every Done pulse consumes one expected response.
    always @(negedge clk) begin
        if (FetchDone || AluDone) begin
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_done", {62'd0, FetchDone, AluDone}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("done_owner", {61'd0, AluDone, FetchDone, Owner}, {61'd0, e.alu, !e.alu, e.alu});
                chk("done_data", {32'd0, (e.alu ? AluRData : FetchData)}, {32'd0, e.data});
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, {57'd0, MemIO, MemWDataOE, FetchDone, AluDone, Busy, Owner, Timeout}, 64'd0);
        chk({tag, "_bus"}, {MemAddr, MemWData}, 64'd0);
        chk({tag, "_data"}, {FetchData, AluRData}, 64'd0);
    endtask

    task automatic access(input bit alu, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits, input int exp_len);
        bit got;
        @(negedge clk);
        wait_cfg = waits;
        oe_bad   = 1'b0;
        if (alu) begin
            AluReq = 1'b1; AluWrite = wr; AluAddr = addr; AluWData = wd;
        end else begin
            FetchReq = 1'b1; FetchAddr = addr;
        end
        @(negedge clk);
        FetchReq = 1'b0;
        AluReq   = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (FetchDone || AluDone) got = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", {63'd0, got}, 64'd1);
        chk("access_len", last_len, exp_len);
        chk("access_io", {62'd0, last_io}, wr ? 64'd2 : 64'd1);
        chk("access_addr", {32'd0, last_addr}, {32'd0, addr});
        chk("access_oe", {63'd0, oe_bad}, 64'd0);
        if (wr) chk("access_wdata", {32'd0, last_wdata}, {32'd0, wd});
        chk("done_bus_idle", {61'd0, MemIO, MemWDataOE}, 64'd0);
        @(negedge clk);
        chk("idle_after", {63'd0, Busy}, 64'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Fetch read, zero wait
        rdata_cfg = 32'h1334;  // ^0x100 -> 0x1234
        sb.push_back('{1'b0, 32'h0000_1234});
        access(1'b0, 1'b0, 32'h100, 32'h0, 0, 1);

        // ALU read, one wait cycle
        rdata_cfg = 32'hDEAD_BDEF;  // ^0x300 -> 0xDEADBEEF
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        access(1'b1, 1'b0, 32'h300, 32'h0, 1, 2);

        // ALU write, three wait cycles: AluRData must keep the previous read
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        access(1'b1, 1'b1, 32'h200, 32'hA5A5_A5A5, 3, 4);
        chk("fetch_hold", {32'd0, FetchData}, 64'h1234);

`ifdef MEM_ARB_TIMEOUT_EN
        sb.push_back('{1'b0, 32'hFFFF_FFFF});
        access(1'b0, 1'b0, 32'h700, 32'h0, 1000, 16);
        chk("timeout_set", {63'd0, Timeout}, 64'd1);
        rdata_cfg = 32'h0;
        sb.push_back('{1'b0, 32'h0000_0100});
        access(1'b0, 1'b0, 32'h100, 32'h0, 0, 1);
        chk("timeout_sticky", {63'd0, Timeout}, 64'd1);
`else
        chk("timeout_tied", {63'd0, Timeout}, 64'd0);
`endif

        // Both requesting from reset: ALU, fetch, ALU, fetch, 3 cycles apart
        @(negedge clk);
        rst = 1'b1;
        FetchReq = 1'b1; FetchAddr = 32'h400;
        AluReq = 1'b1; AluWrite = 1'b0; AluAddr = 32'h500;
        wait_cfg = 0; rdata_cfg = 32'h0;
        @(negedge clk);
        check_reset("tie_reset");
        done_cyc.delete();
        sb.push_back('{1'b1, 32'h500});
        sb.push_back('{1'b0, 32'h400});
        sb.push_back('{1'b1, 32'h500});
        sb.push_back('{1'b0, 32'h400});
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (FetchDone || AluDone) n++;
        end
        FetchReq = 1'b0;
        AluReq   = 1'b0;
        chk("tie_dones", n, 4);
        repeat (2) @(negedge clk);
        chk("tie_count", done_cyc.size(), 4);
        for (int i = 1; i < done_cyc.size(); i++)
            chk("tie_spacing", done_cyc[i] - done_cyc[i-1], 3);

        // Reset in the 2nd ACCESS cycle of an ALU read: dropped, no Done
        @(negedge clk);
        wait_cfg = 5;
        AluReq = 1'b1; AluWrite = 1'b0; AluAddr = 32'h600;
        @(negedge clk);
        AluReq = 1'b0;
        chk("pre_rst_owner", {62'd0, Owner, MemIO == 2'b01}, 64'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", {63'd0, Busy}, 64'd0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
